// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the MIPS memory bus: arbiter states, master ids,
// and the bus widths reused by the CPU and the bus memory.
package bus_arbiter_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 32;
    localparam int unsigned BUS_DATA_WIDTH = 32;
    localparam int unsigned BUS_BE_WIDTH   = BUS_DATA_WIDTH / 8;

    // Encodings are visible on grant_state, so they are fixed explicitly.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_e;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } master_id_e;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_if.sv
// Bundle of every bus signal around the arbiter: the instruction-fetch port,
// the data load/store port and the slave (bus memory) port.
// Modport "master" is the arbiter's view (it masters the slave side);
// modport "slave" is the view of the surrounding CPU ports and memory.
interface bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Instruction-fetch master (read-only)
    logic [ADDR_WIDTH-1:0] i_address;
    logic                  i_read;
    logic                  i_waitrequest;
    logic [DATA_WIDTH-1:0] i_readdata;

    // Data load/store master
    logic [ADDR_WIDTH-1:0] d_address;
    logic                  d_read;
    logic                  d_write;
    logic [DATA_WIDTH-1:0] d_writedata;
    logic [BE_WIDTH-1:0]   d_byteenable;
    logic                  d_waitrequest;
    logic [DATA_WIDTH-1:0] d_readdata;

    // Slave (bus memory)
    logic [ADDR_WIDTH-1:0] m_address;
    logic                  m_read;
    logic                  m_write;
    logic [DATA_WIDTH-1:0] m_writedata;
    logic [BE_WIDTH-1:0]   m_byteenable;
    logic                  m_waitrequest;
    logic [DATA_WIDTH-1:0] m_readdata;

    modport master (
        input  i_address, i_read,
        output i_waitrequest, i_readdata,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata
    );

    modport slave (
        output i_address, i_read,
        input  i_waitrequest, i_readdata,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata
    );

endinterface : bus_arbiter_if

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin tie-break between the two masters. Purely combinational:
// a lone requester wins outright; on a tie the master that was not granted
// last wins.
module rr_picker
    import bus_arbiter_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  master_id_e last_grant,
    output logic       win_valid,
    output master_id_e winner
);

    // Pick the winner for the next grant
    always_comb begin
        win_valid = req_i | req_d;
        winner    = INSTR;
        if (req_i && req_d) begin
            winner = (last_grant == INSTR) ? DATA : INSTR;
        end else if (req_d) begin
            winner = DATA;
        end
    end

endmodule : rr_picker

// File: rtl/bus_arbiter.sv
// Two-master / one-slave arbiter for the MIPS CPU memory bus. Serialises
// instruction-fetch and data accesses, forwards the granted master to the
// slave, and releases a grant whose slave stalls too long (sticky error).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16   // legal range 2..255
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_arbiter_if.master        bus,
    output logic [1:0]           grant_state,
    output logic                 timeout_err
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0]  WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e state_q, state_d;
    master_id_e last_grant_q, last_grant_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    logic       req_i, req_d;
    logic       win_valid;
    master_id_e winner;

    logic                  granted;
    logic                  granted_req;
    master_id_e            granted_id;

    logic [ADDR_WIDTH-1:0] m_address_c;
    logic                  m_read_c;
    logic                  m_write_c;
    logic [DATA_WIDTH-1:0] m_writedata_c;
    logic [BE_WIDTH-1:0]   m_byteenable_c;
    logic                  i_wait_c;
    logic                  d_wait_c;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

    rr_picker u_rr_picker (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant_q),
        .win_valid  (win_valid),
        .winner     (winner)
    );

    // Next-state, watchdog and slave-side forwarding
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_err_d  = timeout_err_q;
        m_address_c    = '0;
        m_read_c       = 1'b0;
        m_write_c      = 1'b0;
        m_writedata_c  = '0;
        m_byteenable_c = '0;
        i_wait_c       = req_i;
        d_wait_c       = req_d;
        granted        = 1'b0;
        granted_req    = 1'b0;
        granted_id     = INSTR;

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (win_valid) begin
                    state_d = (winner == DATA) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                granted        = 1'b1;
                granted_req    = req_i;
                granted_id     = INSTR;
                m_address_c    = bus.i_address;
                m_read_c       = bus.i_read;
                m_byteenable_c = '1;
                i_wait_c       = req_i & bus.m_waitrequest;
            end
            GRANT_D: begin
                granted        = 1'b1;
                granted_req    = req_d;
                granted_id     = DATA;
                m_address_c    = bus.d_address;
                m_read_c       = bus.d_read;
                m_write_c      = bus.d_write;
                m_writedata_c  = bus.d_writedata;
                m_byteenable_c = bus.d_byteenable;
                d_wait_c       = req_d & bus.m_waitrequest;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Both grant states share one exit policy: abort, complete, time out
        // or keep counting stalled cycles.
        if (granted) begin
            if (!granted_req) begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else if (!bus.m_waitrequest) begin
                state_d      = IDLE;
                last_grant_d = granted_id;
                wait_cnt_d   = '0;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
                state_d       = IDLE;
                last_grant_d  = granted_id;
                timeout_err_d = 1'b1;
                wait_cnt_d    = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    // State, round-robin history, watchdog counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= INSTR;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.m_address     = m_address_c;
    assign bus.m_read        = m_read_c;
    assign bus.m_write       = m_write_c;
    assign bus.m_writedata   = m_writedata_c;
    assign bus.m_byteenable  = m_byteenable_c;
    assign bus.i_waitrequest = i_wait_c;
    assign bus.d_waitrequest = d_wait_c;
    assign bus.i_readdata    = bus.m_readdata;
    assign bus.d_readdata    = bus.m_readdata;

    assign grant_state = state_q;
    assign timeout_err = timeout_err_q;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: single write, tie-break, continuous
// contention, watchdog timeout, abort, asynchronous reset and read data.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] grant_state;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    // Slave model controls
    logic        stall_forever;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_cnt;

    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    bus_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant_state (grant_state),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: releases waitrequest on the third cycle of a request
    always @(posedge clk) begin
        if (bus.m_read || bus.m_write)
            slv_cnt <= (slv_cnt == 2'd2) ? 2'd0 : slv_cnt + 2'd1;
        else
            slv_cnt <= 2'd0;
    end
    assign bus.m_waitrequest = stall_forever |
                               !((bus.m_read | bus.m_write) && (slv_cnt == 2'd2));
    assign bus.m_readdata    = slv_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_address    = '0;
        bus.i_read       = 1'b0;
        bus.d_address    = '0;
        bus.d_read       = 1'b0;
        bus.d_write      = 1'b0;
        bus.d_writedata  = '0;
        bus.d_byteenable = '0;
        stall_forever    = 1'b0;
    endtask

    // Advance to just after the next rising edge (start of a new cycle)
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    logic [1:0] order [6];
    logic [1:0] order_exp [6];
    int         n_tr;
    logic [1:0] prev_gs;

    initial begin
        reset     = 1'b1;
        slv_rdata = 32'h0;
        slv_cnt   = 2'd0;
        clear_inputs();
        order_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_state",   grant_state, 2'b00);
        chk("rst_err",     timeout_err, 1'b0);
        chk("rst_m_read",  bus.m_read, 1'b0);
        chk("rst_m_write", bus.m_write, 1'b0);
        chk("rst_m_addr",  bus.m_address, 32'h0);
        chk("rst_m_be",    bus.m_byteenable, 4'h0);
        chk("rst_i_wait",  bus.i_waitrequest, 1'b0);
        next_cycle();
        reset = 1'b0;

        // ---------------- lone data write ----------------
        next_cycle();                                   // cycle 0
        bus.d_write      = 1'b1;
        bus.d_address    = 32'h10;
        bus.d_writedata  = 32'hDEADBEEF;
        bus.d_byteenable = 4'hF;
        @(negedge clk);
        chk("wr_c0_state", grant_state, 2'b00);
        chk("wr_c0_dwait", bus.d_waitrequest, 1'b1);
        chk("wr_c0_mwr",   bus.m_write, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk("wr_state", grant_state, 2'b10);
            chk("wr_mwr",   bus.m_write, 1'b1);
            chk("wr_mrd",   bus.m_read, 1'b0);
            chk("wr_addr",  bus.m_address, 32'h10);
            chk("wr_data",  bus.m_writedata, 32'hDEADBEEF);
            chk("wr_be",    bus.m_byteenable, 4'hF);
            chk("wr_dwait", bus.d_waitrequest, (c == 3) ? 1'b0 : 1'b1);
        end
        next_cycle();                                   // cycle 4
        bus.d_write = 1'b0;
        @(negedge clk);
        chk("wr_c4_state", grant_state, 2'b00);
        chk("wr_c4_mwr",   bus.m_write, 1'b0);

        // ---------------- simultaneous requests after reset + read data ----------------
        do_reset();
        slv_rdata = 32'h12345678;
        next_cycle();                                   // cycle 0
        bus.i_read    = 1'b1;
        bus.i_address = 32'h100;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h200;
        @(negedge clk);
        chk("tie_c0_state", grant_state, 2'b00);
        chk("tie_c0_iwait", bus.i_waitrequest, 1'b1);
        chk("tie_c0_dwait", bus.d_waitrequest, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk("tie_d_state", grant_state, 2'b10);
            chk("tie_d_mrd",   bus.m_read, 1'b1);
            chk("tie_d_addr",  bus.m_address, 32'h200);
            chk("tie_d_iwait", bus.i_waitrequest, 1'b1);
            chk("tie_d_dwait", bus.d_waitrequest, (c == 3) ? 1'b0 : 1'b1);
        end
        next_cycle();                                   // cycle 4
        bus.d_read = 1'b0;
        @(negedge clk);
        chk("tie_c4_state", grant_state, 2'b00);
        chk("tie_c4_iwait", bus.i_waitrequest, 1'b1);
        chk("tie_c4_mrd",   bus.m_read, 1'b0);
        for (int c = 5; c <= 7; c++) begin
            next_cycle();
            @(negedge clk);
            chk("tie_i_state", grant_state, 2'b01);
            chk("tie_i_mrd",   bus.m_read, 1'b1);
            chk("tie_i_mwr",   bus.m_write, 1'b0);
            chk("tie_i_addr",  bus.m_address, 32'h100);
            chk("tie_i_be",    bus.m_byteenable, 4'hF);
            chk("tie_i_iwait", bus.i_waitrequest, (c == 7) ? 1'b0 : 1'b1);
        end
        chk("rd_idata", bus.i_readdata, 32'h12345678);
        next_cycle();                                   // cycle 8
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("tie_c8_state", grant_state, 2'b00);

        // ---------------- continuous contention ----------------
        do_reset();
        next_cycle();
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        n_tr    = 0;
        prev_gs = 2'b00;
        for (int c = 0; c < 60 && n_tr < 6; c++) begin
            @(negedge clk);
            if (grant_state != 2'b00 && prev_gs == 2'b00) begin
                order[n_tr] = grant_state;
                n_tr++;
            end
            prev_gs = grant_state;
        end
        chk("cont_count", n_tr, 6);
        for (int k = 0; k < n_tr; k++) begin
            chk($sformatf("cont_order%0d", k), order[k], order_exp[k]);
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;

        // ---------------- watchdog timeout ----------------
        do_reset();
        stall_forever = 1'b1;
        next_cycle();                                   // cycle 0
        bus.i_read    = 1'b1;
        bus.i_address = 32'h40;
        @(negedge clk);
        chk("to_c0_state", grant_state, 2'b00);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk("to_grant_state", grant_state, 2'b01);
            chk("to_grant_err",   timeout_err, 1'b0);
            chk("to_grant_iwait", bus.i_waitrequest, 1'b1);
        end
        next_cycle();                                   // cycle 5
        @(negedge clk);
        chk("to_c5_state", grant_state, 2'b00);
        chk("to_c5_mrd",   bus.m_read, 1'b0);
        chk("to_c5_err",   timeout_err, 1'b1);
        chk("to_c5_iwait", bus.i_waitrequest, 1'b1);
        next_cycle();                                   // cycle 6
        @(negedge clk);
        chk("to_c6_state", grant_state, 2'b01);
        chk("to_c6_mrd",   bus.m_read, 1'b1);
        chk("to_c6_err",   timeout_err, 1'b1);
        next_cycle();                                   // cycle 7
        bus.i_read    = 1'b0;
        stall_forever = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("to_sticky_state", grant_state, 2'b00);
        chk("to_sticky_err",   timeout_err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("to_cleared_err", timeout_err, 1'b0);

        // ---------------- abort, then reset mid-grant ----------------
        do_reset();
        next_cycle();                                   // cycle 0
        bus.d_read    = 1'b1;
        bus.d_address = 32'h80;
        bus.i_read    = 1'b1;
        bus.i_address = 32'hC0;
        next_cycle();                                   // cycle 1
        @(negedge clk);
        chk("ab_c1_state", grant_state, 2'b10);
        next_cycle();                                   // cycle 2
        bus.d_read = 1'b0;
        @(negedge clk);
        chk("ab_c2_state", grant_state, 2'b10);
        chk("ab_c2_mrd",   bus.m_read, 1'b0);
        chk("ab_c2_dwait", bus.d_waitrequest, 1'b0);
        chk("ab_c2_iwait", bus.i_waitrequest, 1'b1);
        next_cycle();                                   // cycle 3
        @(negedge clk);
        chk("ab_c3_state", grant_state, 2'b00);
        next_cycle();                                   // cycle 4
        @(negedge clk);
        chk("ab_c4_state", grant_state, 2'b01);
        chk("ab_c4_mrd",   bus.m_read, 1'b1);
        chk("ab_c4_addr",  bus.m_address, 32'hC0);
        next_cycle();                                   // cycle 5, still granted
        chk("rst_mid_pre", grant_state, 2'b01);
        reset = 1'b1;
        #1;
        chk("rst_mid_mrd",   bus.m_read, 1'b0);
        chk("rst_mid_state", grant_state, 2'b00);
        next_cycle();
        clear_inputs();
        reset = 1'b0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_bus_arbiter
